stepper_io_array: RTL and testbench
===================================

Name: stepper_io_array

Overview:
Memory-mapped multi-channel stepper controller for the CPU I/O space. It replaces the single-channel stepper hook-up. SW/LW to addresses with bit 12 set reach this block. Each of NUM_CH channels independently generates step/dir pulse trains with a programmable half-period, tracks signed position, and reports busy/done/error status. Pin outputs drive the Pmod header.

Parameters:
NUM_CH, 4, number of independent stepper channels (1..16)
COUNT_W, 24, width of step-remaining counter per channel
PERIOD_W, 20, width of half-period register (clock cycles)
POS_W, 32, width of signed position accumulator
RESET_PERIOD, 50000, half-period loaded at reset (1 kHz step rate at 100 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
io_addr  in  32  CPU data address
io_wdata  in  32  store data
io_we  in  1  store strobe, qualified by io_addr[12]
io_re  in  1  load strobe, qualified by io_addr[12]
io_rdata  out  32  load data, registered
step  out  NUM_CH  step pulse per channel
dir  out  NUM_CH  direction per channel (1 = positive)
irq  out  1  OR of all channels' done&irq_en bits

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. On reset, step=0, dir=0, irq=0, io_rdata=0, all channels IDLE, remaining=0, position=0, period=RESET_PERIOD, done/err/irq_en=0.
- Decode: sel = io_addr[12]. ch = io_addr[7:4]. reg = io_addr[3:2]. Accesses with ch >= NUM_CH are ignored, and reads of them return 0.
- Register map:
  - reg0 CMD (W): signed step count.
  - reg1 PERIOD (W/R): half-period.
  - reg2 STATUS (R): {busy[31], done[30], err[29], irq_en[28], remaining zero-extended [27:0]}. W: bit0 clears done, bit1 clears err, bit2 sets irq_en.
  - reg3 POS (R): signed position. W: aborts the move; position is preserved.
- Read latency: io_rdata is updated on the clock edge after io_re&sel and holds until the next read. Simultaneous io_we and io_re to the same register: the read returns the pre-write value.
- Channel FSM states: IDLE, HIGH, LOW. A half-period counter hc reloads from period on each state entry.
- IDLE + CMD write, nonzero: dir <= wdata[31]==0. remaining <= |wdata| truncated to COUNT_W. done <= 0. Next state HIGH.
- IDLE + CMD write of 0: sets done, stays IDLE.
- CMD write while busy (HIGH/LOW): ignored; err <= 1.
- HIGH: step=1. When hc hits 1, go to LOW.
- LOW: step=0. When hc hits 1: remaining--, position += dir?+1:-1 (wraps modulo 2^POS_W). If the new remaining is 0, go to IDLE and set done; otherwise go to HIGH.
- Period 0 is treated as 1, giving the minimum 2-cycle step period. A PERIOD write during a move takes effect at the next state entry.
- Abort (POS write) in HIGH: step drops the next cycle, no position update, remaining <= 0, go to IDLE, done <= 1.
- Abort in LOW: go to IDLE, no count.
- Abort in IDLE: no effect.
- STATUS clear and a done-set in the same cycle: set wins.
- dir is held stable while busy.
- Reset mid-move: all outputs go low immediately (asynchronous).
- irq is registered: irq <= |(done & irq_en).

Test Plan:
- Reset, then set PERIOD ch0=2 and CMD ch0=+3 -> 3 step pulses, each 2 cycles high and 2 low, dir0=1; after the last low phase busy=0, done=1, POS ch0=3.
- CMD ch1=-5 at period 1 -> 5 pulses of 1 cycle high and 1 low, dir1=0; POS ch1 reads 0xFFFFFFFB; STATUS remaining reads 0.
- CMD ch2=+10, then a second CMD while busy -> the second command is ignored, err=1, exactly 10 pulses; STATUS write 0x2 clears err.
- CMD ch0=+100 at period 4, POS write after 7 pulses -> step low within 1 cycle, POS=7, busy=0, done=1.
- STATUS write 0x4 on ch3, CMD +1 -> irq rises 1 cycle after done sets; STATUS write 0x1 drops irq on the following cycle.
- Assert rst_n=0 mid-pulse on all 4 channels -> step and dir go to 0 asynchronously; after release, all registers read reset values and PERIOD reads 50000.

Source files
------------

// File: rtl/stepper_io_array.sv
// Memory-mapped multi-channel stepper pulse generator for the CPU I/O space.
// Each channel runs an IDLE/HIGH/LOW pulse FSM with its own half-period, step count and position.
module stepper_io_array #(
  parameter int NUM_CH       = 4,
  parameter int COUNT_W      = 24,
  parameter int PERIOD_W     = 20,
  parameter int POS_W        = 32,
  parameter int RESET_PERIOD = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       io_addr,
  input  logic [31:0]       io_wdata,
  input  logic              io_we,
  input  logic              io_re,
  output logic [31:0]       io_rdata,
  output logic [NUM_CH-1:0] step,
  output logic [NUM_CH-1:0] dir,
  output logic              irq
);

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_POS    = 2'd3;

  state_t                     state      [NUM_CH];
  state_t                     state_nxt  [NUM_CH];
  logic        [PERIOD_W-1:0] hc         [NUM_CH];
  logic        [PERIOD_W-1:0] hc_nxt     [NUM_CH];
  logic        [PERIOD_W-1:0] period     [NUM_CH];
  logic        [PERIOD_W-1:0] period_nxt [NUM_CH];
  logic        [COUNT_W-1:0]  rem        [NUM_CH];
  logic        [COUNT_W-1:0]  rem_nxt    [NUM_CH];
  logic signed [POS_W-1:0]    pos        [NUM_CH];
  logic signed [POS_W-1:0]    pos_nxt    [NUM_CH];

  logic [NUM_CH-1:0] done, done_nxt;
  logic [NUM_CH-1:0] err, err_nxt;
  logic [NUM_CH-1:0] irq_en, irq_en_nxt;
  logic [NUM_CH-1:0] dir_nxt;
  logic [NUM_CH-1:0] hit;
  logic [31:0]       rdata_nxt;
  logic              irq_nxt;

  logic       sel;
  logic [3:0] ch_idx;
  logic [1:0] reg_idx;
  logic       ch_ok;
  logic       wr_en;
  logic       rd_en;
  logic       unused_bits;

  assign sel     = io_addr[12];
  assign ch_idx  = io_addr[7:4];
  assign reg_idx = io_addr[3:2];
  assign ch_ok   = int'(ch_idx) < NUM_CH;
  assign wr_en   = io_we && sel && ch_ok;
  assign rd_en   = io_re && sel;
  assign unused_bits = ^{io_addr[31:13], io_addr[11:8], io_addr[1:0]};

  // A programmed half-period of 0 behaves like 1 so the FSM always advances.
  function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] per);
    return (per == '0) ? PERIOD_W'(1) : per;
  endfunction

  function automatic logic [COUNT_W-1:0] step_mag(input logic signed [31:0] cmd);
    logic [31:0] mag;
    mag = cmd[31] ? 32'(-cmd) : 32'(cmd);
    return mag[COUNT_W-1:0];
  endfunction

  always_comb begin
    hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hit[c] = wr_en && (ch_idx == 4'(c));
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      step[c] = (state[c] == HIGH);
    end
  end

  always_comb begin
    done_nxt   = done;
    err_nxt    = err;
    irq_en_nxt = irq_en;
    dir_nxt    = dir;
    for (int c = 0; c < NUM_CH; c++) begin
      state_nxt[c]  = state[c];
      hc_nxt[c]     = hc[c];
      period_nxt[c] = period[c];
      rem_nxt[c]    = rem[c];
      pos_nxt[c]    = pos[c];

      if (hit[c] && reg_idx == REG_PERIOD) period_nxt[c] = io_wdata[PERIOD_W-1:0];

      // Clears are applied first so a done-set later in this block wins.
      if (hit[c] && reg_idx == REG_STATUS) begin
        if (io_wdata[0]) done_nxt[c]   = 1'b0;
        if (io_wdata[1]) err_nxt[c]    = 1'b0;
        if (io_wdata[2]) irq_en_nxt[c] = 1'b1;
      end

      case (state[c])
        IDLE: begin
          if (hit[c] && reg_idx == REG_CMD) begin
            if (io_wdata == 32'd0) begin
              done_nxt[c] = 1'b1;
            end else begin
              dir_nxt[c]   = ~io_wdata[31];
              rem_nxt[c]   = step_mag(io_wdata);
              done_nxt[c]  = 1'b0;
              state_nxt[c] = HIGH;
              hc_nxt[c]    = eff_period(period[c]);
            end
          end
        end
        HIGH, LOW: begin
          if (hit[c] && reg_idx == REG_CMD) err_nxt[c] = 1'b1;
          if (hit[c] && reg_idx == REG_POS) begin
            state_nxt[c] = IDLE;
            rem_nxt[c]   = '0;
            done_nxt[c]  = 1'b1;
          end else if (hc[c] > PERIOD_W'(1)) begin
            hc_nxt[c] = hc[c] - PERIOD_W'(1);
          end else if (state[c] == HIGH) begin
            state_nxt[c] = LOW;
            hc_nxt[c]    = eff_period(period[c]);
          end else begin
            rem_nxt[c] = rem[c] - COUNT_W'(1);
            pos_nxt[c] = dir[c] ? pos[c] + POS_W'(1) : pos[c] - POS_W'(1);
            if (rem[c] == COUNT_W'(1)) begin
              state_nxt[c] = IDLE;
              done_nxt[c]  = 1'b1;
            end else begin
              state_nxt[c] = HIGH;
              hc_nxt[c]    = eff_period(period[c]);
            end
          end
        end
        default: state_nxt[c] = IDLE;
      endcase
    end
  end

  // Read path samples current state, so a same-cycle write is seen by the next read.
  always_comb begin
    rdata_nxt = io_rdata;
    if (rd_en) begin
      rdata_nxt = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_idx == 4'(c)) begin
          case (reg_idx)
            REG_PERIOD: rdata_nxt = 32'(period[c]);
            REG_STATUS: rdata_nxt = {state[c] != IDLE, done[c], err[c], irq_en[c], 28'(rem[c])};
            REG_POS:    rdata_nxt = 32'(pos[c]);
            default:    rdata_nxt = '0;
          endcase
        end
      end
    end
  end

  assign irq_nxt = |(done & irq_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state[c]  <= IDLE;
        hc[c]     <= '0;
        period[c] <= PERIOD_W'(RESET_PERIOD);
        rem[c]    <= '0;
        pos[c]    <= '0;
      end
      done     <= '0;
      err      <= '0;
      irq_en   <= '0;
      dir      <= '0;
      irq      <= 1'b0;
      io_rdata <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state[c]  <= state_nxt[c];
        hc[c]     <= hc_nxt[c];
        period[c] <= period_nxt[c];
        rem[c]    <= rem_nxt[c];
        pos[c]    <= pos_nxt[c];
      end
      done     <= done_nxt;
      err      <= err_nxt;
      irq_en   <= irq_en_nxt;
      dir      <= dir_nxt;
      irq      <= irq_nxt;
      io_rdata <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_stepper_io_array.sv
// Directed bench for stepper_io_array: pulse trains, position, status, abort, irq and async reset.
module tb_stepper_io_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_rdata;
  logic [3:0]  step;
  logic [3:0]  dir;
  logic        irq;

  int check_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  stepper_io_array #(
    .NUM_CH(4), .COUNT_W(24), .PERIOD_W(20), .POS_W(32), .RESET_PERIOD(50000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_we(io_we), .io_re(io_re), .io_rdata(io_rdata),
    .step(step), .dir(dir), .irq(irq)
  );

  function automatic logic [31:0] addr_of(input int c, input int r);
    return 32'h1000 | (32'(c) << 4) | (32'(r) << 2);
  endfunction

  // Tasks are entered and left on a falling edge.
  task automatic bus_write(input int c, input int r, input logic [31:0] d);
    io_addr = addr_of(c, r); io_wdata = d; io_we = 1'b1;
    @(negedge clk);
    io_we = 1'b0;
  endtask

  task automatic bus_read(input int c, input int r, output logic [31:0] d);
    io_addr = addr_of(c, r); io_re = 1'b1;
    @(negedge clk);
    io_re = 1'b0; d = io_rdata;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    check_cnt++; if (step !== 4'h0) $display("FAIL reset_step got %h want 0", step); else pass_cnt++;
    check_cnt++; if (dir !== 4'h0) $display("FAIL reset_dir got %h want 0", dir); else pass_cnt++;
    check_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else pass_cnt++;
    check_cnt++; if (io_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", io_rdata); else pass_cnt++;
    bus_read(0, 1, d);
    check_cnt++; if (d !== 32'd50000) $display("FAIL reset_period got %0d want 50000", d); else pass_cnt++;
    bus_read(2, 2, d);
    check_cnt++; if (d !== 32'h0) $display("FAIL reset_status got %h want 0", d); else pass_cnt++;
  endtask

  task automatic test_positive_move();
    logic [31:0] d;
    logic [15:0] seen;
    bus_write(0, 1, 32'd2);
    bus_write(0, 0, 32'd3);
    for (int i = 0; i < 16; i++) begin
      seen[i] = step[0];
      @(negedge clk);
    end
    check_cnt++; if (seen !== 16'h0333) $display("FAIL pos_move_wave got %h want 0333", seen); else pass_cnt++;
    check_cnt++; if (dir[0] !== 1'b1) $display("FAIL pos_move_dir got %b want 1", dir[0]); else pass_cnt++;
    bus_read(0, 2, d);
    check_cnt++; if (d !== 32'h4000_0000) $display("FAIL pos_move_status got %h want 40000000", d); else pass_cnt++;
    bus_read(0, 3, d);
    check_cnt++; if (d !== 32'd3) $display("FAIL pos_move_pos got %h want 3", d); else pass_cnt++;
  endtask

  task automatic test_negative_move();
    logic [31:0] d;
    logic [15:0] seen;
    logic        dir_seen;
    bus_write(1, 1, 32'd1);
    bus_write(1, 0, 32'hFFFF_FFFB);
    dir_seen = dir[1];
    for (int i = 0; i < 16; i++) begin
      seen[i] = step[1];
      @(negedge clk);
    end
    check_cnt++; if (seen !== 16'h0155) $display("FAIL neg_move_wave got %h want 0155", seen); else pass_cnt++;
    check_cnt++; if (dir_seen !== 1'b0) $display("FAIL neg_move_dir got %b want 0", dir_seen); else pass_cnt++;
    bus_read(1, 3, d);
    check_cnt++; if (d !== 32'hFFFF_FFFB) $display("FAIL neg_move_pos got %h want fffffffb", d); else pass_cnt++;
    bus_read(1, 2, d);
    check_cnt++; if (d !== 32'h4000_0000) $display("FAIL neg_move_status got %h want 40000000", d); else pass_cnt++;
  endtask

  task automatic test_busy_error();
    logic [31:0] d;
    logic [23:0] seen;
    bus_write(2, 1, 32'd0);
    bus_write(2, 0, 32'd10);
    seen[0] = step[2];
    bus_write(2, 0, 32'd3);
    for (int i = 1; i < 24; i++) begin
      seen[i] = step[2];
      @(negedge clk);
    end
    check_cnt++; if (seen !== 24'h055555) $display("FAIL busy_wave got %h want 055555", seen); else pass_cnt++;
    bus_read(2, 2, d);
    check_cnt++; if (d !== 32'h6000_0000) $display("FAIL busy_err_status got %h want 60000000", d); else pass_cnt++;
    bus_read(2, 3, d);
    check_cnt++; if (d !== 32'd10) $display("FAIL busy_pos got %h want 10", d); else pass_cnt++;
    bus_write(2, 2, 32'h2);
    bus_read(2, 2, d);
    check_cnt++; if (d !== 32'h4000_0000) $display("FAIL err_clear got %h want 40000000", d); else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic        prev;
    int          rises;
    do_reset();
    bus_write(0, 1, 32'd4);
    bus_write(0, 0, 32'd100);
    prev  = 1'b0;
    rises = 0;
    for (int i = 0; i < 200; i++) begin
      if (step[0] && !prev) rises++;
      prev = step[0];
      if (rises == 8) break;
      @(negedge clk);
    end
    check_cnt++; if (rises != 8) $display("FAIL abort_wait got %0d rises want 8", rises); else pass_cnt++;
    bus_write(0, 3, 32'd0);
    check_cnt++; if (step[0] !== 1'b0) $display("FAIL abort_step got %b want 0", step[0]); else pass_cnt++;
    bus_read(0, 3, d);
    check_cnt++; if (d !== 32'd7) $display("FAIL abort_pos got %h want 7", d); else pass_cnt++;
    bus_read(0, 2, d);
    check_cnt++; if (d !== 32'h4000_0000) $display("FAIL abort_status got %h want 40000000", d); else pass_cnt++;
  endtask

  task automatic test_irq();
    bus_write(3, 2, 32'h4);
    bus_write(3, 1, 32'd1);
    bus_write(3, 0, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check_cnt++; if (irq !== 1'b0) $display("FAIL irq_at_done got %b want 0", irq); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (irq !== 1'b1) $display("FAIL irq_rise got %b want 1", irq); else pass_cnt++;
    bus_write(3, 2, 32'h1);
    check_cnt++; if (irq !== 1'b1) $display("FAIL irq_hold got %b want 1", irq); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (irq !== 1'b0) $display("FAIL irq_drop got %b want 0", irq); else pass_cnt++;
  endtask

  task automatic test_rw_collision();
    logic [31:0] d;
    io_addr = addr_of(1, 1); io_wdata = 32'd77; io_we = 1'b1; io_re = 1'b1;
    @(negedge clk);
    io_we = 1'b0; io_re = 1'b0;
    check_cnt++; if (io_rdata !== 32'd50000) $display("FAIL rw_old_value got %0d want 50000", io_rdata); else pass_cnt++;
    bus_read(1, 1, d);
    check_cnt++; if (d !== 32'd77) $display("FAIL rw_new_value got %0d want 77", d); else pass_cnt++;
    bus_write(5, 1, 32'd9);
    bus_read(5, 1, d);
    check_cnt++; if (d !== 32'h0) $display("FAIL bad_channel_read got %h want 0", d); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    for (int c = 0; c < 4; c++) bus_write(c, 1, 32'd10);
    for (int c = 0; c < 4; c++) bus_write(c, 0, 32'd5);
    check_cnt++; if (step !== 4'hF) $display("FAIL pre_reset_step got %h want f", step); else pass_cnt++;
    check_cnt++; if (dir !== 4'hF) $display("FAIL pre_reset_dir got %h want f", dir); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    check_cnt++; if (step !== 4'h0) $display("FAIL async_step got %h want 0", step); else pass_cnt++;
    check_cnt++; if (dir !== 4'h0) $display("FAIL async_dir got %h want 0", dir); else pass_cnt++;
    check_cnt++; if (io_rdata !== 32'h0) $display("FAIL async_rdata got %h want 0", io_rdata); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(3, 1, d);
    check_cnt++; if (d !== 32'd50000) $display("FAIL post_reset_period got %0d want 50000", d); else pass_cnt++;
    bus_read(1, 2, d);
    check_cnt++; if (d !== 32'h0) $display("FAIL post_reset_status got %h want 0", d); else pass_cnt++;
    bus_read(1, 3, d);
    check_cnt++; if (d !== 32'h0) $display("FAIL post_reset_pos got %h want 0", d); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", check_cnt);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; io_addr = '0; io_wdata = '0; io_we = 1'b0; io_re = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_positive_move();
    test_negative_move();
    test_busy_error();
    test_abort();
    test_irq();
    test_rw_collision();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
